// File: rtl/arm_multicycle_datapath_pkg.sv
// Shared encodings for the multicycle ARM datapath and controller.
// ALU ops, select constants, flag indices and the immediate extender.
package arm_mc_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    localparam logic [1:0] IMM_B8   = 2'b00;
    localparam logic [1:0] IMM_B12  = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;

    localparam logic [1:0] SRCA_A   = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Branch offsets are word counts, hence the shift by two.
    function automatic logic [31:0] ext_imm(
        input logic [23:0] f,
        input logic [1:0]  src
    );
        logic [31:0] r;
        r = 32'd0;
        case (src)
            IMM_B8:  r = {24'd0, f[7:0]};
            IMM_B12: r = {20'd0, f[11:0]};
            IMM_BR:  r = {{6{f[23]}}, f, 2'b00};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_multicycle_datapath_if.sv
// Unified instruction/data memory bus of the multicycle core.
// The datapath is the master; memory answers combinationally.
interface arm_multicycle_datapath_if;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output Adr, output WriteData, input ReadData);
    modport slave  (input Adr, input WriteData, output ReadData);
endinterface

// File: rtl/arm_multicycle_datapath_regfile.sv
// R0-R14 register file; address 15 reads the external R15 value.
// Writes to 15 are dropped, so the PC only moves through PCWrite.
module arm_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [3:0]  a1_i,
    input  logic [3:0]  a2_i,
    input  logic [3:0]  a3_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] r15_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] regs_q [0:14];

    // Clear on reset, otherwise write the addressed register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= 32'd0;
        end else if (we_i && (a3_i != 4'd15)) begin
            regs_q[a3_i] <= wd_i;
        end
    end

    assign rd1_o = (a1_i == 4'd15) ? r15_i : regs_q[a1_i];
    assign rd2_o = (a2_i == 4'd15) ? r15_i : regs_q[a2_i];
endmodule

// File: rtl/arm_multicycle_datapath.sv
// Datapath half of the multicycle ARM core.
// Holds PC, IR and the inter-cycle registers; ALU and muxes inline.
module arm_multicycle_datapath
    import arm_mc_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCWrite,
    input  logic                     RegWrite,
    input  logic                     IRWrite,
    input  logic                     AdrSrc,
    input  logic [1:0]               RegSrc,
    input  logic [1:0]               ALUSrcA,
    input  logic [1:0]               ALUSrcB,
    input  logic [1:0]               ResultSrc,
    input  logic [1:0]               ImmSrc,
    input  logic [1:0]               ALUControl,
    arm_multicycle_datapath_if.master mem,
    output logic [19:0]              Instr,
    output logic [3:0]               ALUFlags
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] data_q, a_q, b_q, aluout_q;
    logic [WIDTH-1:0] rd1, rd2, result, imm;
    logic [WIDTH-1:0] src_a, src_b, b_op, alu_res;
    logic [WIDTH:0]   sum;
    logic [3:0]       ra1, ra2;
    logic             is_sub, c_flag, v_flag;

    assign imm   = ext_imm(ir_q[23:0], ImmSrc);
    assign src_a = (ALUSrcA == SRCA_PC) ? pc_q : a_q;
    assign src_b = (ALUSrcB == SRCB_B)   ? b_q :
                   (ALUSrcB == SRCB_IMM) ? imm : 32'd4;

    assign is_sub = (ALUControl == ALU_SUB);
    assign b_op   = is_sub ? ~src_b : src_b;
    assign sum    = {1'b0, src_a} + {1'b0, b_op} + {32'd0, is_sub};

    // ALU result plus carry/overflow; logic ops clear C and V.
    always_comb begin
        alu_res = sum[31:0];
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: begin
                alu_res = sum[31:0];
                c_flag  = sum[32];
                v_flag  = (src_a[31] == b_op[31]) &&
                          (sum[31] != src_a[31]);
            end
            ALU_AND: alu_res = src_a & src_b;
            default: alu_res = src_a | src_b;
        endcase
    end

    assign ALUFlags[FLAG_N] = alu_res[31];
    assign ALUFlags[FLAG_Z] = (alu_res == 32'd0);
    assign ALUFlags[FLAG_C] = c_flag;
    assign ALUFlags[FLAG_V] = v_flag;

    assign result = (ResultSrc == RES_DATA) ? data_q  :
                    (ResultSrc == RES_ALU)  ? alu_res : aluout_q;

    assign ra1 = RegSrc[0] ? 4'd15 : ir_q[19:16];
    assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];

    arm_regfile u_rf (
        .clk   (clk),
        .reset (reset),
        .we_i  (RegWrite),
        .a1_i  (ra1),
        .a2_i  (ra2),
        .a3_i  (ir_q[15:12]),
        .wd_i  (result),
        .r15_i (result),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign pc_d = PCWrite ? result : pc_q;
    assign ir_d = IRWrite ? mem.ReadData : ir_q;

    // Architectural PC/IR plus the free-running inter-cycle latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            data_q   <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            data_q   <= mem.ReadData;
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= alu_res;
        end
    end

    assign mem.Adr       = AdrSrc ? result : pc_q;
    assign mem.WriteData = b_q;
    assign Instr         = ir_q[31:12];
endmodule

// File: tb/tb_arm_multicycle_datapath.sv
// Randomized bench for arm_multicycle_datapath with an
// architectural reference model and directed literal checks.
module tb_arm_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    arm_multicycle_datapath_if bus ();

    arm_multicycle_datapath #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .mem        (bus),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_aluout;
    logic [31:0] m_r [0:14];

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] adr;
        logic [31:0] alu;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [3:0]  fl;
    } comb_t;

    function automatic comb_t eval();
        comb_t e;
        logic [31:0] imm, sa, sb, alu;
        logic c, v;
        int sa_s, sb_s;
        longint s;
        logic [3:0] r1, r2;
        case (ImmSrc)
            2'd0: imm = {24'd0, m_ir[7:0]};
            2'd1: imm = {20'd0, m_ir[11:0]};
            2'd2: imm = {{6{m_ir[23]}}, m_ir[23:0], 2'b00};
            default: imm = 32'd0;
        endcase
        sa = (ALUSrcA == 2'b01) ? m_pc : m_a;
        sb = (ALUSrcB == 2'b00) ? m_b : (ALUSrcB == 2'b01) ? imm : 32'd4;
        sa_s = sa;
        sb_s = sb;
        c = 1'b0;
        v = 1'b0;
        case (ALUControl)
            2'd0: begin
                alu = sa + sb;
                c = (alu < sa);
                s = longint'(sa_s) + longint'(sb_s);
                v = (s != longint'(int'(s)));
            end
            2'd1: begin
                alu = sa - sb;
                c = (sa >= sb);
                s = longint'(sa_s) - longint'(sb_s);
                v = (s != longint'(int'(s)));
            end
            2'd2: alu = sa & sb;
            default: alu = sa | sb;
        endcase
        e.alu = alu;
        e.fl = {alu[31], alu == 32'd0, c, v};
        case (ResultSrc)
            2'd1: e.res = m_data;
            2'd2: e.res = alu;
            default: e.res = m_aluout;
        endcase
        r1 = RegSrc[0] ? 4'd15 : m_ir[19:16];
        r2 = RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
        e.rd1 = (r1 == 4'd15) ? e.res : m_r[r1];
        e.rd2 = (r2 == 4'd15) ? e.res : m_r[r2];
        e.adr = AdrSrc ? e.res : m_pc;
        return e;
    endfunction

    comb_t mc;
    always_comb mc = eval();

    // Advance the reference model on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 32'd0;
            m_ir <= 32'd0;
            m_data <= 32'd0;
            m_a <= 32'd0;
            m_b <= 32'd0;
            m_aluout <= 32'd0;
            for (int i = 0; i < 15; i++) m_r[i] <= 32'd0;
        end else begin
            if (PCWrite) m_pc <= mc.res;
            if (IRWrite) m_ir <= bus.ReadData;
            m_data <= bus.ReadData;
            m_a <= mc.rd1;
            m_b <= mc.rd2;
            m_aluout <= mc.alu;
            if (RegWrite && m_ir[15:12] != 4'd15)
                m_r[m_ir[15:12]] <= mc.res;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_adr", bus.Adr, mc.adr);
            chk("m_wdata", bus.WriteData, m_b);
            chk("m_instr", {12'd0, Instr}, {12'd0, m_ir[31:12]});
            chk("m_flags", {28'd0, ALUFlags}, {28'd0, mc.fl});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        PCWrite = 1'b0;
        RegWrite = 1'b0;
        IRWrite = 1'b0;
        AdrSrc = 1'b0;
        RegSrc = 2'b00;
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b00;
        ResultSrc = 2'b00;
        ImmSrc = 2'b00;
        ALUControl = 2'b00;
    endtask

    task automatic fetch(input logic [31:0] w);
        idle();
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        bus.ReadData = w;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;
        PCWrite = 1'b1;
        IRWrite = 1'b1;
        bus.ReadData = 32'hFFFF_FFFF;
        #1;
        step();
        step();
        idle();
        chk_en = 1'b1;
        #2;
        chk("rst_adr", bus.Adr, 32'h0);
        chk("rst_instr", {12'd0, Instr}, 32'h0);
        chk("rst_wdata", bus.WriteData, 32'h0);

        fetch(32'hE04F_000F);
        step();
        #2;
        chk("f1_instr", {12'd0, Instr}, 32'h000E_04F0);
        chk("f1_adr", bus.Adr, 32'h4);
        step();
        #2;
        chk("f2_adr", bus.Adr, 32'h8);

        idle();
        RegSrc = 2'b01;
        ResultSrc = 2'b00;
        step();
        idle();
        ALUControl = 2'b01;
        AdrSrc = 1'b1;
        ResultSrc = 2'b10;
        #2;
        chk("sub_flags", {28'd0, ALUFlags}, 32'b0110);
        chk("sub_res", bus.Adr, 32'h0);
        step();
        idle();
        RegWrite = 1'b1;
        step();

        fetch(32'hE591_1001);
        step();
        idle();
        bus.ReadData = 32'h7FFF_FFFF;
        step();
        idle();
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
        step();
        idle();
        step();
        idle();
        ALUSrcB = 2'b01;
        AdrSrc = 1'b1;
        ResultSrc = 2'b10;
        #2;
        chk("ld_r1", bus.WriteData, 32'h7FFF_FFFF);
        chk("add_res", bus.Adr, 32'h8000_0000);
        chk("add_flags", {28'd0, ALUFlags}, 32'b1001);
        step();

        fetch(32'hEAFF_FFFE);
        step();
        idle();
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc = 2'b10;
        AdrSrc = 1'b1;
        ResultSrc = 2'b10;
        #2;
        chk("ext_br", bus.Adr, 32'h8);
        chk("ext_br_fl", {28'd0, ALUFlags}, 32'b0010);
        step();
        fetch(32'hE3A0_0ABC);
        step();
        idle();
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc = 2'b01;
        AdrSrc = 1'b1;
        ResultSrc = 2'b10;
        #2;
        chk("ext_b12", bus.Adr, 32'h0000_0AD0);
        step();

        fetch(32'hE002_2002);
        step();
        idle();
        bus.ReadData = 32'h5;
        step();
        idle();
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
        step();
        idle();
        #2;
        chk("rdw_old", bus.WriteData, 32'h0);
        step();
        #2;
        chk("rdw_new", bus.WriteData, 32'h5);

        fetch(32'hE00F_F002);
        step();
        idle();
        RegWrite = 1'b1;
        ResultSrc = 2'b10;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        step();
        idle();
        step();
        #2;
        chk("a3_15", bus.WriteData, 32'h5);

        idle();
        reset = 1'b1;
        PCWrite = 1'b1;
        IRWrite = 1'b1;
        RegWrite = 1'b1;
        bus.ReadData = 32'hFFFF_FFFF;
        step();
        idle();
        #2;
        chk("mid_adr", bus.Adr, 32'h0);
        chk("mid_instr", {12'd0, Instr}, 32'h0);
        chk("mid_wdata", bus.WriteData, 32'h0);
        fetch(32'hE00F_F002);
        step();
        idle();
        step();
        #2;
        chk("mid_r2", bus.WriteData, 32'h0);

        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(63) == 0);
            PCWrite = 1'($urandom);
            RegWrite = 1'($urandom);
            IRWrite = 1'($urandom);
            AdrSrc = 1'($urandom);
            RegSrc = 2'($urandom);
            ALUSrcA = 2'($urandom);
            ALUSrcB = 2'($urandom);
            ResultSrc = 2'($urandom);
            ImmSrc = 2'($urandom);
            ALUControl = 2'($urandom);
            case ($urandom_range(5))
                0: bus.ReadData = 32'h0;
                1: bus.ReadData = 32'h7FFF_FFFF;
                2: bus.ReadData = 32'h8000_0000;
                3: bus.ReadData = 32'hFFFF_FFFF;
                default: bus.ReadData = $urandom;
            endcase
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
